// File: rtl/bias_add_sat_stream.sv
// Per-tile bias add on a TILE_SIZE-lane stream: synchronous bias lookup, saturating add,
// optional ReLU, and a credit-guarded output FIFO so backpressure never drops a beat.
module bias_add_sat_stream #(
    parameter int unsigned TILE_SIZE  = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_TILES    = 64,
    parameter int unsigned BADDR_W    = $clog2(N_TILES),
    parameter int unsigned OUT_DEPTH  = 5,
    parameter bit          SAT_EN     = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] in_vec,
    input  logic                            in_relu_en,
    input  logic                            tile_idx_clr,
    input  logic                            bias_we,
    input  logic [BADDR_W-1:0]              bias_waddr,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] bias_wdata,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [TILE_SIZE*DATA_WIDTH-1:0] out_vec,
    output logic [BADDR_W-1:0]              out_tile_idx,
    output logic [TILE_SIZE-1:0]            out_sat
);

    localparam int unsigned VEC_W = TILE_SIZE * DATA_WIDTH;
    localparam int unsigned SUM_W = DATA_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    localparam logic [DATA_WIDTH-1:0] LANE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] LANE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Bias storage is deliberately not reset so tables survive a stream reset.
    logic [VEC_W-1:0] bias_mem [N_TILES];

    always_ff @(posedge clk) begin
        if (bias_we) begin
            bias_mem[bias_waddr] <= bias_wdata;
        end
    end

    logic                 in_ready_q, in_ready_d;
    logic [CNT_W-1:0]     inflight_q, inflight_d;
    logic [BADDR_W-1:0]   tile_q, tile_d;

    logic                 s0_valid_q, s0_valid_d;
    logic [VEC_W-1:0]     s0_vec_q, s0_vec_d;
    logic                 s0_relu_q, s0_relu_d;
    logic [BADDR_W-1:0]   s0_idx_q, s0_idx_d;

    logic                 s1_valid_q, s1_valid_d;
    logic [VEC_W-1:0]     s1_vec_q, s1_vec_d;
    logic                 s1_relu_q, s1_relu_d;
    logic [BADDR_W-1:0]   s1_idx_q, s1_idx_d;
    logic [VEC_W-1:0]     s1_bias_q, s1_bias_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [VEC_W-1:0]     s2_vec_q, s2_vec_d;
    logic [BADDR_W-1:0]   s2_idx_q, s2_idx_d;
    logic [TILE_SIZE-1:0] s2_sat_q, s2_sat_d;

    logic [VEC_W-1:0]     fifo_vec_q [OUT_DEPTH];
    logic [VEC_W-1:0]     fifo_vec_d [OUT_DEPTH];
    logic [BADDR_W-1:0]   fifo_idx_q [OUT_DEPTH];
    logic [BADDR_W-1:0]   fifo_idx_d [OUT_DEPTH];
    logic [TILE_SIZE-1:0] fifo_sat_q [OUT_DEPTH];
    logic [TILE_SIZE-1:0] fifo_sat_d [OUT_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     fcnt_q, fcnt_d;

    logic                 out_valid_q, out_valid_d;
    logic [VEC_W-1:0]     out_vec_q, out_vec_d;
    logic [BADDR_W-1:0]   out_idx_q, out_idx_d;
    logic [TILE_SIZE-1:0] out_sat_q, out_sat_d;

    logic                  accept;
    logic                  fire;
    logic [BADDR_W-1:0]    idx_use;
    logic [SUM_W-1:0]      lane_a;
    logic [SUM_W-1:0]      lane_b;
    logic [SUM_W-1:0]      lane_sum;
    logic [DATA_WIDTH-1:0] lane_res;

    always_comb begin
        accept     = in_valid & in_ready_q;
        fire       = out_valid_q & out_ready;
        idx_use    = tile_idx_clr ? '0 : tile_q;
        lane_a     = '0;
        lane_b     = '0;
        lane_sum   = '0;
        lane_res   = '0;

        tile_d     = tile_q;
        s0_valid_d = accept;
        s0_vec_d   = s0_vec_q;
        s0_relu_d  = s0_relu_q;
        s0_idx_d   = s0_idx_q;
        s1_valid_d = s0_valid_q;
        s1_vec_d   = s0_vec_q;
        s1_relu_d  = s0_relu_q;
        s1_idx_d   = s0_idx_q;
        s1_bias_d  = bias_mem[s0_idx_q];
        s2_valid_d = s1_valid_q;
        s2_vec_d   = '0;
        s2_idx_d   = s1_idx_q;
        s2_sat_d   = '0;
        fifo_vec_d = fifo_vec_q;
        fifo_idx_d = fifo_idx_q;
        fifo_sat_d = fifo_sat_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        // Clear wins over the running count; a clearing beat itself is tile 0.
        if (accept) begin
            tile_d    = (idx_use == BADDR_W'(N_TILES - 1)) ? '0 : idx_use + 1'b1;
            s0_vec_d  = in_vec;
            s0_relu_d = in_relu_en;
            s0_idx_d  = idx_use;
        end else if (tile_idx_clr) begin
            tile_d = '0;
        end

        for (int unsigned l = 0; l < TILE_SIZE; l++) begin
            lane_a   = {s1_vec_q[l*DATA_WIDTH + DATA_WIDTH - 1], s1_vec_q[l*DATA_WIDTH +: DATA_WIDTH]};
            lane_b   = {s1_bias_q[l*DATA_WIDTH + DATA_WIDTH - 1], s1_bias_q[l*DATA_WIDTH +: DATA_WIDTH]};
            lane_sum = lane_a + lane_b;
            if (SAT_EN && (lane_sum[SUM_W-1] != lane_sum[SUM_W-2])) begin
                lane_res    = lane_sum[SUM_W-1] ? LANE_MIN : LANE_MAX;
                s2_sat_d[l] = 1'b1;
            end else begin
                lane_res = lane_sum[DATA_WIDTH-1:0];
            end
            if (s1_relu_q && lane_res[DATA_WIDTH-1]) begin
                lane_res = '0;
            end
            s2_vec_d[l*DATA_WIDTH +: DATA_WIDTH] = lane_res;
        end

        if (s2_valid_q) begin
            fifo_vec_d[wr_ptr_q] = s2_vec_q;
            fifo_idx_d[wr_ptr_q] = s2_idx_q;
            fifo_sat_d[wr_ptr_q] = s2_sat_q;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (fire) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        fcnt_d = fcnt_q + CNT_W'(s2_valid_q) - CNT_W'(fire);

        // Output registers mirror the next FIFO head so the port is flop-driven.
        out_valid_d = (fcnt_d != '0);
        out_vec_d   = fifo_vec_d[rd_ptr_d];
        out_idx_d   = fifo_idx_d[rd_ptr_d];
        out_sat_d   = fifo_sat_d[rd_ptr_d];

        // Credits cover pipeline plus FIFO, so in_ready never looks at out_ready directly.
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(fire);
        in_ready_d = (inflight_d < CNT_W'(OUT_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b0;
            inflight_q  <= '0;
            tile_q      <= '0;
            s0_valid_q  <= 1'b0;
            s0_vec_q    <= '0;
            s0_relu_q   <= 1'b0;
            s0_idx_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_vec_q    <= '0;
            s1_relu_q   <= 1'b0;
            s1_idx_q    <= '0;
            s1_bias_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_vec_q    <= '0;
            s2_idx_q    <= '0;
            s2_sat_q    <= '0;
            fifo_vec_q  <= '{default: '0};
            fifo_idx_q  <= '{default: '0};
            fifo_sat_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_idx_q   <= '0;
            out_sat_q   <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            inflight_q  <= inflight_d;
            tile_q      <= tile_d;
            s0_valid_q  <= s0_valid_d;
            s0_vec_q    <= s0_vec_d;
            s0_relu_q   <= s0_relu_d;
            s0_idx_q    <= s0_idx_d;
            s1_valid_q  <= s1_valid_d;
            s1_vec_q    <= s1_vec_d;
            s1_relu_q   <= s1_relu_d;
            s1_idx_q    <= s1_idx_d;
            s1_bias_q   <= s1_bias_d;
            s2_valid_q  <= s2_valid_d;
            s2_vec_q    <= s2_vec_d;
            s2_idx_q    <= s2_idx_d;
            s2_sat_q    <= s2_sat_d;
            fifo_vec_q  <= fifo_vec_d;
            fifo_idx_q  <= fifo_idx_d;
            fifo_sat_q  <= fifo_sat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
            out_idx_q   <= out_idx_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_vec      = out_vec_q;
    assign out_tile_idx = out_idx_q;
    assign out_sat      = out_sat_q;

endmodule

// File: tb/tb_bias_add_sat_stream.sv
// Directed bench for bias_add_sat_stream: one saturating and one wrapping instance share stimulus.
module tb_bias_add_sat_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_relu_en, tile_idx_clr, bias_we, out_ready;
    logic [63:0] in_vec, bias_wdata;
    logic [5:0]  bias_waddr;
    logic        in_ready, out_valid, w_in_ready, w_out_valid;
    logic [63:0] out_vec, w_out_vec;
    logic [5:0]  out_tile_idx, w_out_tile_idx;
    logic [3:0]  out_sat, w_out_sat;

    int n_tests = 0;
    int n_fail  = 0;
    int send_err = 0;
    int cyc = 0;

    logic [63:0] fv[$];
    logic [5:0]  ft[$];
    logic [3:0]  fs[$];
    int          fc[$];
    int          ac[$];
    logic [63:0] wv[$];
    logic [3:0]  ws[$];

    bias_add_sat_stream #(.SAT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .in_relu_en(in_relu_en), .tile_idx_clr(tile_idx_clr), .bias_we(bias_we),
        .bias_waddr(bias_waddr), .bias_wdata(bias_wdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_vec(out_vec), .out_tile_idx(out_tile_idx), .out_sat(out_sat)
    );

    bias_add_sat_stream #(.SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .in_vec(in_vec),
        .in_relu_en(in_relu_en), .tile_idx_clr(tile_idx_clr), .bias_we(bias_we),
        .bias_waddr(bias_waddr), .bias_wdata(bias_wdata), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_vec(w_out_vec), .out_tile_idx(w_out_tile_idx), .out_sat(w_out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Record accepts and fires just before the edge that performs them.
    always @(negedge clk) begin
        if (in_valid && in_ready) ac.push_back(cyc);
        if (out_valid && out_ready) begin
            fv.push_back(out_vec); ft.push_back(out_tile_idx); fs.push_back(out_sat); fc.push_back(cyc);
        end
        if (w_out_valid && out_ready) begin
            wv.push_back(w_out_vec); ws.push_back(w_out_sat);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    task automatic clear_q();
        fv.delete(); ft.delete(); fs.delete(); fc.delete(); ac.delete(); wv.delete(); ws.delete();
        send_err = 0;
    endtask

    task automatic write_bias(input int addr, input logic [63:0] data);
        bias_we = 1'b1; bias_waddr = 6'(addr); bias_wdata = data;
        @(posedge clk); #1;
        bias_we = 1'b0;
    endtask

    task automatic send(input logic [63:0] v, input logic relu, input logic clr);
        bit got;
        got = 1'b0;
        in_valid = 1'b1; in_vec = v; in_relu_en = relu; tile_idx_clr = clr;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_relu_en = 1'b0; tile_idx_clr = 1'b0;
        if (!got) send_err++;
    endtask

    task automatic wait_fires(input int n);
        for (int i = 0; i < 300 && fv.size() < n; i++) @(negedge clk);
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_vec = '0; in_relu_en = 0; tile_idx_clr = 0;
        bias_we = 0; bias_waddr = '0; bias_wdata = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++; if ({out_vec, out_tile_idx, out_sat} !== '0) begin
            n_fail++; $display("FAIL reset_out_data got=%h/%0d/%b exp=0", out_vec, out_tile_idx, out_sat); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge got=%b exp=1", in_ready); end
    endtask

    task automatic test_stream();
        logic [63:0] exp;
        for (int a = 0; a < 64; a++) write_bias(a, pack4(1000+4*a, 1001+4*a, 1002+4*a, 1003+4*a));
        clear_q();
        for (int i = 0; i < 65; i++) send(pack4(1, 2, 3, 4), 1'b0, 1'b0);
        wait_fires(65);
        n_tests++; if (send_err !== 0) begin n_fail++; $display("FAIL stream_send_timeout got=%0d exp=0", send_err); end
        n_tests++; if (fv.size() !== 65) begin n_fail++; $display("FAIL stream_count got=%0d exp=65", fv.size()); end
        if (fv.size() == 65 && ac.size() == 65) begin
            for (int i = 0; i < 65; i++) begin
                exp = pack4(1001+4*(i%64), 1003+4*(i%64), 1005+4*(i%64), 1007+4*(i%64));
                n_tests++; if (fv[i] !== exp) begin n_fail++; $display("FAIL stream_vec[%0d] got=%h exp=%h", i, fv[i], exp); end
                n_tests++; if (ft[i] !== 6'(i%64) || fs[i] !== 4'b0) begin
                    n_fail++; $display("FAIL stream_tag[%0d] got=%0d/%b exp=%0d/0000", i, ft[i], fs[i], i%64); end
            end
            n_tests++; if (fc[0] - ac[0] !== 4) begin n_fail++; $display("FAIL stream_latency got=%0d exp=4", fc[0]-ac[0]); end
            n_tests++; if (ac[64] - ac[0] !== 64 || fc[64] - fc[0] !== 64) begin
                n_fail++; $display("FAIL stream_rate got=%0d/%0d exp=64/64", ac[64]-ac[0], fc[64]-fc[0]); end
        end
    endtask

    task automatic test_saturation();
        logic [63:0] exp_s [2];
        logic [63:0] exp_w [2];
        logic [3:0]  exp_f [2];
        exp_s[0] = pack4('h7FFF, 'h7FFF, 'h7FFF, 'h7F00); exp_f[0] = 4'b0011;
        exp_w[0] = pack4('h8100, 'h8000, 'h7FFF, 'h7F00);
        exp_s[1] = pack4('h8000, 'h8000, 'hFF05, 'h8000); exp_f[1] = 4'b1001;
        exp_w[1] = pack4('h7F00, 'h8000, 'hFF05, 'h7F01);
        write_bias(0, pack4('h7F00, 'h7F00, 'h7F00, 'h7F00));
        write_bias(1, pack4('hFF00, 'hFF00, 'hFF00, 'hFF00));
        clear_q();
        send(pack4('h0200, 'h0100, 'h00FF, 'h0000), 1'b0, 1'b1);
        send(pack4('h8000, 'h8100, 'h0005, 'h8001), 1'b0, 1'b0);
        wait_fires(2);
        n_tests++; if (fv.size() !== 2 || wv.size() !== 2) begin
            n_fail++; $display("FAIL sat_count got=%0d/%0d exp=2/2", fv.size(), wv.size()); end
        if (fv.size() == 2 && wv.size() == 2) begin
            for (int i = 0; i < 2; i++) begin
                n_tests++; if (fv[i] !== exp_s[i] || fs[i] !== exp_f[i]) begin
                    n_fail++; $display("FAIL sat_clamp[%0d] got=%h/%b exp=%h/%b", i, fv[i], fs[i], exp_s[i], exp_f[i]); end
                n_tests++; if (wv[i] !== exp_w[i] || ws[i] !== 4'b0) begin
                    n_fail++; $display("FAIL sat_wrap[%0d] got=%h/%b exp=%h/0000", i, wv[i], ws[i], exp_w[i]); end
            end
        end
    endtask

    task automatic test_relu();
        logic [63:0] exp [3];
        logic [3:0]  exf [3];
        exp[0] = pack4(0, 0, 0, 12);     exf[0] = 4'b0000;
        exp[1] = pack4(-3, -3, -3, 12);  exf[1] = 4'b0000;
        exp[2] = pack4(0, 0, 0, 0);      exf[2] = 4'b0001;
        write_bias(0, pack4(2, 2, 2, 2));
        write_bias(1, pack4(2, 2, 2, 2));
        write_bias(2, pack4(-256, -256, -256, -256));
        clear_q();
        send(pack4(-5, -5, -5, 10), 1'b1, 1'b1);
        send(pack4(-5, -5, -5, 10), 1'b0, 1'b0);
        send(pack4(-32768, 256, 256, 256), 1'b1, 1'b0);
        wait_fires(3);
        n_tests++; if (fv.size() !== 3) begin n_fail++; $display("FAIL relu_count got=%0d exp=3", fv.size()); end
        if (fv.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_tests++; if (fv[i] !== exp[i] || fs[i] !== exf[i]) begin
                    n_fail++; $display("FAIL relu[%0d] got=%h/%b exp=%h/%b", i, fv[i], fs[i], exp[i], exf[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [63:0] exp;
        for (int a = 0; a < 10; a++) write_bias(a, pack4(a, a, a, a));
        clear_q();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            n = ac.size();
            in_vec = pack4(16*n, 16*n+1, 16*n+2, 16*n+3); tile_idx_clr = (n == 0);
            @(posedge clk); #1;
        end
        n_tests++; if (ac.size() !== 5) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=5", ac.size()); end
        n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_flags got=%b/%b exp=0/1", in_ready, out_valid); end
        n_tests++; if (out_vec !== pack4(0, 1, 2, 3) || out_tile_idx !== 6'd0 || fv.size() !== 0) begin
            n_fail++; $display("FAIL bp_hold got=%h/%0d/%0d exp=%h/0/0", out_vec, out_tile_idx, fv.size(), pack4(0,1,2,3)); end
        out_ready = 1'b1;
        for (int c = 0; c < 100 && ac.size() < 10; c++) begin
            n = ac.size();
            in_vec = pack4(16*n, 16*n+1, 16*n+2, 16*n+3); tile_idx_clr = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_fires(10);
        n_tests++; if (fv.size() !== 10 || ac.size() !== 10) begin
            n_fail++; $display("FAIL bp_count got=%0d/%0d exp=10/10", fv.size(), ac.size()); end
        if (fv.size() == 10) begin
            for (int j = 0; j < 10; j++) begin
                exp = pack4(17*j, 17*j+1, 17*j+2, 17*j+3);
                n_tests++; if (fv[j] !== exp || ft[j] !== 6'(j)) begin
                    n_fail++; $display("FAIL bp_order[%0d] got=%h/%0d exp=%h/%0d", j, fv[j], ft[j], exp, j); end
            end
        end
    endtask

    task automatic test_hazard_clr();
        for (int a = 0; a < 10; a++) write_bias(a, pack4(10*a+5, 10*a+5, 10*a+5, 10*a+5));
        clear_q();
        for (int i = 0; i < 4; i++) send(pack4(0, 1, 2, 3), 1'b0, i == 0);
        write_bias(3, pack4(777, 777, 777, 777));
        for (int i = 4; i < 14; i++) send(pack4(0, 1, 2, 3), 1'b0, i == 10);
        wait_fires(14);
        n_tests++; if (fv.size() !== 14 || send_err !== 0) begin
            n_fail++; $display("FAIL hz_count got=%0d/%0d exp=14/0", fv.size(), send_err); end
        if (fv.size() == 14) begin
            n_tests++; if (fv[3] !== pack4(35, 36, 37, 38)) begin
                n_fail++; $display("FAIL hz_old_bias got=%h exp=%h", fv[3], pack4(35,36,37,38)); end
            n_tests++; if (fv[13] !== pack4(777, 778, 779, 780) || ft[13] !== 6'd3) begin
                n_fail++; $display("FAIL hz_new_bias got=%h/%0d exp=%h/3", fv[13], ft[13], pack4(777,778,779,780)); end
            n_tests++; if (ft[9] !== 6'd9 || ft[10] !== 6'd0 || ft[11] !== 6'd1) begin
                n_fail++; $display("FAIL clr_tags got=%0d/%0d/%0d exp=9/0/1", ft[9], ft[10], ft[11]); end
        end
    endtask

    task automatic test_reset_inflight();
        clear_q();
        for (int i = 0; i < 3; i++) send(pack4(0, 1, 2, 3), 1'b0, i == 0);
        rst_n = 1'b0; #1;
        n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_flags got=%b/%b exp=0/0", in_ready, out_valid); end
        n_tests++; if ({out_vec, out_tile_idx, out_sat} !== '0) begin
            n_fail++; $display("FAIL rst_mid_data got=%h/%0d/%b exp=0", out_vec, out_tile_idx, out_sat); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        n_tests++; if (fv.size() !== 0) begin n_fail++; $display("FAIL rst_dropped got=%0d exp=0", fv.size()); end
        send(pack4(0, 1, 2, 3), 1'b0, 1'b0);
        wait_fires(1);
        n_tests++; if (fv.size() !== 1) begin n_fail++; $display("FAIL rst_after_count got=%0d exp=1", fv.size()); end
        if (fv.size() == 1) begin
            n_tests++; if (fv[0] !== pack4(5, 6, 7, 8) || ft[0] !== 6'd0) begin
                n_fail++; $display("FAIL rst_after_beat got=%h/%0d exp=%h/0", fv[0], ft[0], pack4(5,6,7,8)); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_saturation();
        test_relu();
        test_backpressure();
        test_hazard_clr();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
